// File: rtl/dma_pkg.sv
// Shared DMA definitions: channel count, arbiter state encoding, register map.
package dma_pkg;

  localparam int unsigned DMA_NCH      = 4;
  localparam int unsigned DMA_CH_W     = $clog2(DMA_NCH);
  localparam int unsigned DMA_HOLD_TMO = 255;

  // Register file addresses (shared with the DMA register block)
  localparam int unsigned DMA_ADDR_W   = 4;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_CMD    = 4'h8;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_REQ    = 4'h9;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_SMASK  = 4'hA;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_MODE   = 4'hB;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_CLRFF  = 4'hC;
  localparam logic [DMA_ADDR_W-1:0] DMA_REG_MASK   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_XFER    = 3'd3,
    ST_RELEASE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational priority encoder: fixed (ch0 first) or rotating from ptr.
module dma_rr_pick #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [NCH-1:0]  elig,
  input  logic [CH_W-1:0] ptr,
  input  logic            rotate_en,
  output logic [CH_W-1:0] winner,
  output logic            valid
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;

  // Scan upward from the base channel, wrapping, and take the first eligible one
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    base   = rotate_en ? ptr : '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = CH_W'((32'(base) + i) % NCH);
      if (!valid && elig[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA front-end scheduler: DREQ arbitration, HRQ/HLDA handshake, transfer sequencing.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter  int unsigned NCH      = DMA_NCH,
  parameter  int unsigned HOLD_TMO = DMA_HOLD_TMO,
  localparam int unsigned CH_W     = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  dreq,
  input  logic [NCH-1:0]  mask,
  input  logic [NCH-1:0]  block_mode,
  input  logic            rotate_en,
  input  logic            hlda,
  input  logic            xfer_done,
  input  logic            tc,
  output logic            hrq,
  output logic [NCH-1:0]  dack,
  output logic [CH_W-1:0] chan_sel,
  output logic            xfer_start,
  output logic            busy,
  output logic            hold_timeout
);

  localparam int unsigned TMO_W = $clog2(HOLD_TMO + 1);

  dma_state_e       state_q, state_d;
  logic [CH_W-1:0]  chan_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_d;
  logic             hrq_d, xfer_start_d, busy_d;
  logic [NCH-1:0]   dack_d;
  logic [NCH-1:0]   elig;
  logic [CH_W-1:0]  pick;
  logic             pick_valid;

  assign elig = dreq & ~mask;

  dma_rr_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr_q),
    .rotate_en (rotate_en),
    .winner    (pick),
    .valid     (pick_valid)
  );

  // Next state, latched channel, pointer, timeout counter and registered-output values
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_sel;
    ptr_d        = ptr_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_flag_d   = hold_timeout;
    hrq_d        = 1'b0;
    dack_d       = '0;
    xfer_start_d = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d   = ST_REQ;
          tmo_cnt_d = '0;
        end
      end
      ST_REQ: begin
        if (!(|elig)) begin
          state_d = ST_RELEASE;
        end else if (hlda && pick_valid) begin
          chan_d  = pick;
          state_d = ST_GRANT;
        end else if (tmo_cnt_q == TMO_W'(HOLD_TMO - 1)) begin
          tmo_flag_d = 1'b1;
          state_d    = ST_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_GRANT: begin
        state_d = hlda ? ST_XFER : ST_RELEASE;
      end
      ST_XFER: begin
        if (!hlda) begin
          // Bus revoked: abandon without advancing the pointer
          state_d = ST_RELEASE;
        end else if (xfer_done) begin
          ptr_d = CH_W'((32'(chan_sel) + 1) % NCH);
          if (block_mode[chan_sel] && !tc && elig[chan_sel]) begin
            state_d = ST_GRANT;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (!hlda) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!rotate_en) begin
      ptr_d = '0;
    end

    hrq_d        = (state_d == ST_REQ) || (state_d == ST_GRANT) || (state_d == ST_XFER);
    xfer_start_d = (state_d == ST_GRANT);
    busy_d       = (state_d != ST_IDLE);
    if ((state_d == ST_GRANT) || (state_d == ST_XFER)) begin
      dack_d = NCH'(1) << chan_d;
    end
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      chan_sel     <= '0;
      ptr_q        <= '0;
      tmo_cnt_q    <= '0;
      hold_timeout <= 1'b0;
      hrq          <= 1'b0;
      dack         <= '0;
      xfer_start   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_sel     <= chan_d;
      ptr_q        <= ptr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      hold_timeout <= tmo_flag_d;
      hrq          <= hrq_d;
      dack         <= dack_d;
      xfer_start   <= xfer_start_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter: expected grants queued, monitor checks each xfer_start.
module tb_dma_channel_arbiter;
  import dma_pkg::*;

  localparam int unsigned NCH  = DMA_NCH;
  localparam int unsigned CH_W = DMA_CH_W;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  dreq, mask, block_mode;
  logic            rotate_en, hlda, xfer_done, tc;
  logic            hrq, xfer_start, busy, hold_timeout;
  logic [NCH-1:0]  dack;
  logic [CH_W-1:0] chan_sel;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  dma_channel_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .dreq         (dreq),
    .mask         (mask),
    .block_mode   (block_mode),
    .rotate_en    (rotate_en),
    .hlda         (hlda),
    .xfer_done    (xfer_done),
    .tc           (tc),
    .hrq          (hrq),
    .dack         (dack),
    .chan_sel     (chan_sel),
    .xfer_start   (xfer_start),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hrq(input logic lvl);
    int n = 0;
    while (hrq !== lvl && n < 50) begin
      tick();
      n++;
    end
    check("wait_hrq", 32'(hrq), 32'(lvl));
  endtask

  task automatic wait_start();
    int n = 0;
    while (xfer_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("wait_xfer_start", 32'(xfer_start), 32'd1);
  endtask

  // Act as CPU and timing control for one bus tenure of nx transfers on channel ch
  task automatic serve(input int ch, input int nx, input logic blk);
    for (int k = 0; k < nx; k++) exp_q.push_back(ch);
    wait_hrq(1'b1);
    tick();
    tick();
    hlda = 1'b1;
    wait_start();
    for (int k = 0; k < nx; k++) begin
      tick();
      tick();
      xfer_done = 1'b1;
      tc        = blk ? (k == nx - 1) : 1'b0;
      tick();
      xfer_done = 1'b0;
      tc        = 1'b0;
      if (k < nx - 1) begin
        check("blk_restart_lat", 32'(xfer_start), 32'd1);
        check("blk_hrq_held", 32'(hrq), 32'd1);
      end else begin
        check("rel_hrq", 32'(hrq), 32'd0);
        check("rel_dack", 32'(dack), 32'd0);
      end
    end
    hlda = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: every xfer_start must match the next queued channel
  always @(negedge clk) begin
    if (reset === 1'b1 && xfer_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(xfer_start), 32'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("grant_chan", 32'(chan_sel), 32'(e));
        check("grant_dack", 32'(dack), 32'(1) << e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic dack_seen;

    reset = 1'b0; dreq = '0; mask = '0; block_mode = '0;
    rotate_en = 1'b0; hlda = 1'b0; xfer_done = 1'b0; tc = 1'b0;
    repeat (3) tick();
    check("rst_hrq", 32'(hrq), 32'd0);
    check("rst_dack", 32'(dack), 32'd0);
    check("rst_chan_sel", 32'(chan_sel), 32'd0);
    check("rst_xfer_start", 32'(xfer_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold_timeout", 32'(hold_timeout), 32'd0);
    reset = 1'b1;
    tick();

    // Single request, fixed mode
    dreq = 4'b0100;
    serve(2, 1, 1'b0);
    dreq = '0;
    tick();

    // Fixed priority: ch1 beats ch3 every time
    dreq = 4'b1010;
    for (int i = 0; i < 3; i++) serve(1, 1, 1'b0);
    dreq = '0;
    tick();

    // Masked channel ignored
    dreq = 4'b0011; mask = 4'b0001;
    serve(1, 1, 1'b0);
    dreq = '0; mask = '0;
    tick();

    // Rotating priority: 0,1,2,3,0
    rotate_en = 1'b1;
    dreq = 4'b1111;
    serve(0, 1, 1'b0);
    serve(1, 1, 1'b0);
    serve(2, 1, 1'b0);
    serve(3, 1, 1'b0);
    serve(0, 1, 1'b0);
    dreq = '0;
    rotate_en = 1'b0;
    tick();

    // Block mode: four transfers, tc on the fourth
    block_mode = 4'b0001;
    dreq = 4'b0001;
    serve(0, 4, 1'b1);
    dreq = '0;
    tick();

    // Block mode with request dropped mid-transfer releases the bus
    dreq = 4'b0001;
    exp_q.push_back(0);
    wait_hrq(1'b1);
    hlda = 1'b1;
    wait_start();
    dreq = '0;
    tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check("blk_drop_hrq", 32'(hrq), 32'd0);
    check("blk_drop_start", 32'(xfer_start), 32'd0);
    hlda = 1'b0;
    tick();
    check("blk_drop_busy", 32'(busy), 32'd0);
    block_mode = '0;

    // Hold timeout
    dreq = 4'b0001;
    wait_hrq(1'b1);
    n = 0;
    dack_seen = 1'b0;
    while (hold_timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (dack !== '0) dack_seen = 1'b1;
    end
    check("tmo_cycles", 32'(n), 32'd255);
    check("tmo_hrq", 32'(hrq), 32'd0);
    check("tmo_dack_never", 32'(dack_seen), 32'd0);
    dreq = '0;
    tick();
    tick();
    check("tmo_sticky", 32'(hold_timeout), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);

    // Async reset in the middle of a transfer
    dreq = 4'b0100;
    exp_q.push_back(2);
    wait_hrq(1'b1);
    hlda = 1'b1;
    wait_start();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_hrq", 32'(hrq), 32'd0);
    check("arst_dack", 32'(dack), 32'd0);
    check("arst_xfer_start", 32'(xfer_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hold_timeout", 32'(hold_timeout), 32'd0);
    dreq = '0;
    hlda = 1'b0;
    #2;
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_hrq", 32'(hrq), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
